// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. One full-subtractor stage and a registered
// borrow are reused for every bit position, LSB first, so an N-bit subtraction
// takes N clocks after the operands are captured.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high, highest priority
//   start       request; only honoured while idle
//   a           minuend, captured on an accepted start
//   b           subtrahend, captured on an accepted start
//   bin         borrow-in, captured on an accepted start
//   busy        high while bits are being processed
//   done        one-cycle pulse when difference/borrow_out are updated
//   difference  a - b - bin mod 2^WIDTH, held until the next completion
//   borrow_out  1 iff a < b + bin (unsigned), held until the next completion
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;

    logic [WIDTH-1:0] a_q,    a_d;
    logic [WIDTH-1:0] b_q,    b_d;
    logic [WIDTH-1:0] res_q,  res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q,   br_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q,  cnt_d;

    logic             d_bit;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_shift;

    // Single full-subtractor cell operating on the current LSBs.
    assign d_bit    = a_q[0] ^ b_q[0] ^ br_q;
    assign br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // New difference bit enters at the MSB; after WIDTH shifts the first
    // (LSB) result bit has walked down to position 0.
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = d_bit;
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)    state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    br_d  = bin;
                    res_d = '0;
                    cnt_d = '0;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_shift;
                cnt_d = cnt_q + CW'(1);
                // Published outputs only move here, so they stay stable
                // for the whole busy window.
                if (last_bit) begin
                    diff_d = res_shift;
                    bout_d = br_next;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // NOTE: the working registers are cleared on reset as well as the visible
    // outputs, so an aborted operation leaves no stale operand or borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            br_q   <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            br_q   <= br_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            done_q <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // done is registered and only set on the edge that returns to IDLE, so
    // busy and done can never be high together.
    always_comb begin
        busy       = (state_q == SHIFT);
        done       = done_q;
        difference = diff_q;
        borrow_out = bout_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Drives a WIDTH=8 and a WIDTH=1 instance with directed vectors. Each accepted
// start pushes its hand-computed result and the edge count at which done must
// appear; independent monitors pop and compare whenever done is seen.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, bin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start1, bin1;
    logic [0:0] a1, b1;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    exp_t       q8[$];
    exp_t       q1[$];
    int         edge_cnt  = 0;
    int         pass_cnt  = 0;
    int         total_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .difference(diff8), .borrow_out(bout8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .difference(diff1), .borrow_out(bout1)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (done8 !== 1'b0) begin
            check("w8_busy_done_excl", {31'b0, busy8}, 32'd0);
            if (q8.size() == 0) begin
                check("w8_unexpected_done", {31'b0, done8}, 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("w8_difference", {24'b0, diff8}, {24'b0, e.diff});
                check("w8_borrow_out", {31'b0, bout8}, {31'b0, e.bout});
                check("w8_done_latency", edge_cnt, e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (done1 !== 1'b0) begin
            check("w1_busy_done_excl", {31'b0, busy1}, 32'd0);
            if (q1.size() == 0) begin
                check("w1_unexpected_done", {31'b0, done1}, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("w1_difference", {31'b0, diff1}, {24'b0, e.diff});
                check("w1_borrow_out", {31'b0, bout1}, {31'b0, e.bout});
                check("w1_done_latency", edge_cnt, e.due);
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    // Drives a start for one cycle; returns at the negedge after edge E0.
    task automatic start_w8(input logic [7:0] a, input logic [7:0] b,
                            input logic bin, input bit accept,
                            input logic [7:0] ed, input logic eb);
        exp_t e;
        start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        if (accept) begin
            e.diff = ed; e.bout = eb; e.due = edge_cnt + 1 + 8;
            q8.push_back(e);
        end
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic start_w1(input logic a, input logic b, input logic bin,
                            input logic ed, input logic eb);
        exp_t e;
        start1 = 1'b1; a1 = a; b1 = b; bin1 = bin;
        e.diff = {7'b0, ed}; e.bout = eb; e.due = edge_cnt + 1 + 1;
        q1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_idle8(input string name);
        int n = 0;
        while ((q8.size() != 0 || busy8) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, q8.size(), 0);
    endtask

    task automatic wait_idle1(input string name);
        int n = 0;
        while ((q1.size() != 0 || busy1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, q1.size(), 0);
    endtask

    // WIDTH=1 truth table: {a,b,bin} -> {diff,borrow}, hand-derived.
    logic [1:0] fs_tbl [8] = '{2'b00, 2'b11, 2'b11, 2'b01,
                               2'b10, 2'b00, 2'b00, 2'b11};

    initial begin
        int busy_cycles;
        int n;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",       {31'b0, busy8}, 32'd0);
        check("rst_done",       {31'b0, done8}, 32'd0);
        check("rst_difference", {24'b0, diff8}, 32'd0);
        check("rst_borrow_out", {31'b0, bout8}, 32'd0);
        check("rst_busy_w1",    {31'b0, busy1}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 0x5A - 0x3C = 0x1E, busy for exactly 8 cycles
        start_w8(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0);
        busy_cycles = 0;
        repeat (12) begin
            if (busy8) busy_cycles++;
            @(negedge clk);
        end
        check("busy_cycles", busy_cycles, 8);
        wait_idle8("t1_complete");

        // Underflow cases
        start_w8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
        wait_idle8("t2a_complete");
        start_w8(8'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1);
        wait_idle8("t2b_complete");

        // Back-to-back: restart in the done cycle
        start_w8(8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0);
        n = 0;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_first_done_seen", {31'b0, done8}, 32'd1);
        start_w8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0);
        wait_idle8("t3_complete");

        // Start while busy is ignored; outputs hold during busy
        start_w8(8'h33, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0);
        @(negedge clk);
        start_w8(8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        check("t4_diff_held", {24'b0, diff8}, 32'h7F);
        wait_idle8("t4_complete");
        repeat (12) @(negedge clk);
        check("t4_no_restart", {31'b0, busy8}, 32'd0);

        // Reset mid-operation aborts with no done
        start_w8(8'hAA, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check("t5_busy_before_rst", {31'b0, busy8}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy",       {31'b0, busy8}, 32'd0);
        check("t5_done",       {31'b0, done8}, 32'd0);
        check("t5_difference", {24'b0, diff8}, 32'd0);
        check("t5_borrow_out", {31'b0, bout8}, 32'd0);
        repeat (15) @(negedge clk);
        check("t5_still_idle", {31'b0, busy8}, 32'd0);

        // WIDTH=1 full-subtractor truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            logic [1:0] r;
            v = 3'(i);
            r = fs_tbl[i];
            start_w1(v[2], v[1], v[0], r[1], r[0]);
            wait_idle1("w1_complete");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
